// File: rtl/ctrl_pipe_pkg.sv
// Shared definitions for the control-word pipeline: the decoded control bundle,
// default depth and bubble encoding, and the per-slot select encoding.
package ctrl_pipe_pkg;

    typedef struct packed {
        logic [4:0] alu_op;
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic       branch;
        logic       jump;
        logic [1:0] wb_sel;
        logic [2:0] imm_sel;
        logic [4:0] rd;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [1:0] spare;
    } controls_s;

    localparam int          STAGES_DEFAULT   = 3;
    localparam logic [31:0] NOP_CTRL_DEFAULT = '0;

    typedef enum logic [1:0] {
        SEL_LOAD   = 2'd0,
        SEL_HOLD   = 2'd1,
        SEL_BUBBLE = 2'd2
    } slot_sel_e;

    // Flush beats hold; a slot whose source was killed or frozen takes a bubble.
    function automatic slot_sel_e slot_select(input logic flush_here,
                                              input logic hold_here,
                                              input logic block_src);
        slot_sel_e sel;
        if (flush_here)
            sel = SEL_BUBBLE;
        else if (hold_here)
            sel = SEL_HOLD;
        else if (block_src)
            sel = SEL_BUBBLE;
        else
            sel = SEL_LOAD;
        return sel;
    endfunction

endpackage

// File: rtl/ctrl_pipe_slot.sv
// One pipeline slot: a valid bit plus control word with load / hold / bubble select.
module ctrl_pipe_slot
    import ctrl_pipe_pkg::*;
#(
    parameter int            CW       = 32,
    parameter logic [CW-1:0] NOP_CTRL = '0
) (
    input  logic          clk,
    input  logic          reset,
    input  slot_sel_e     sel,
    input  logic          d_valid,
    input  logic [CW-1:0] d_ctrl,
    output logic          q_valid,
    output logic [CW-1:0] q_ctrl
);

    logic          valid_reg;
    logic [CW-1:0] ctrl_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_reg <= 1'b0;
            ctrl_reg  <= NOP_CTRL;
        end else begin
            case (sel)
                SEL_LOAD: begin
                    valid_reg <= d_valid;
                    ctrl_reg  <= d_ctrl;
                end
                SEL_HOLD: begin
                    valid_reg <= valid_reg;
                    ctrl_reg  <= ctrl_reg;
                end
                default: begin
                    valid_reg <= 1'b0;
                    ctrl_reg  <= NOP_CTRL;
                end
            endcase
        end
    end

    assign q_valid = valid_reg;
    assign q_ctrl  = ctrl_reg;

endmodule

// File: rtl/ctrl_pipe.sv
// Control-word pipeline from decode to writeback with per-stage stall, flush,
// valid tracking and a registered in-flight count. Stage 0 is the youngest.
module ctrl_pipe
    import ctrl_pipe_pkg::*;
#(
    parameter int            STAGES   = STAGES_DEFAULT,
    parameter int            CW       = $bits(controls_s),
    parameter logic [CW-1:0] NOP_CTRL = CW'(NOP_CTRL_DEFAULT)
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [CW-1:0]                ctrl_i,
    input  logic                         valid_i,
    input  logic [STAGES-1:0]            stall_i,
    input  logic [STAGES-1:0]            flush_i,
    output logic                         accept_o,
    output logic [STAGES*CW-1:0]         ctrl_o,
    output logic [STAGES-1:0]            valid_o,
    output logic [$clog2(STAGES+1)-1:0]  inflight_o
);

    localparam int IW = $clog2(STAGES+1);

    logic [STAGES-1:0] hold_eff;
    logic [STAGES-1:0] flush_eff;
    logic [STAGES-1:0] src_valid;
    logic [STAGES-1:0] valid_next;
    logic [CW-1:0]     src_ctrl [STAGES];
    slot_sel_e         sel      [STAGES];
    logic [IW-1:0]     inflight_next;
    logic [IW-1:0]     inflight_reg;

    genvar gi;
    generate
        for (gi = 0; gi < STAGES; gi++) begin : g_stage
            // A stall or flush at stage j reaches every stage at or below j.
            assign hold_eff[gi]  = |(stall_i >> gi);
            assign flush_eff[gi] = |(flush_i >> gi);

            if (gi == 0) begin : g_head
                assign src_valid[gi] = valid_i;
                assign src_ctrl[gi]  = ctrl_i;
                assign sel[gi]       = slot_select(flush_eff[gi], hold_eff[gi], 1'b0);
            end else begin : g_body
                assign src_valid[gi] = valid_o[gi-1];
                assign src_ctrl[gi]  = ctrl_o[(gi-1)*CW +: CW];
                assign sel[gi]       = slot_select(flush_eff[gi], hold_eff[gi],
                                                   flush_eff[gi-1] | hold_eff[gi-1]);
            end

            always_comb begin
                valid_next[gi] = 1'b0;
                if (!reset) begin
                    case (sel[gi])
                        SEL_LOAD: valid_next[gi] = src_valid[gi];
                        SEL_HOLD: valid_next[gi] = valid_o[gi];
                        default:  valid_next[gi] = 1'b0;
                    endcase
                end
            end

            ctrl_pipe_slot #(
                .CW       (CW),
                .NOP_CTRL (NOP_CTRL)
            ) u_slot (
                .clk     (clk),
                .reset   (reset),
                .sel     (sel[gi]),
                .d_valid (src_valid[gi]),
                .d_ctrl  (src_ctrl[gi]),
                .q_valid (valid_o[gi]),
                .q_ctrl  (ctrl_o[gi*CW +: CW])
            );
        end
    endgenerate

    always_comb begin
        inflight_next = '0;
        for (int k = 0; k < STAGES; k++)
            inflight_next = inflight_next + IW'(valid_next[k]);
    end

    always_ff @(posedge clk) begin
        if (reset)
            inflight_reg <= '0;
        else
            inflight_reg <= inflight_next;
    end

    assign inflight_o = inflight_reg;
    assign accept_o   = ~hold_eff[0] & ~flush_eff[0] & ~reset;

endmodule

// File: tb/tb_ctrl_pipe.sv
// Bench for ctrl_pipe: directed scenarios on a 3-stage/32-bit pipe, then a
// randomized 5-stage/8-bit sweep checked against a queued reference model.
module tb_ctrl_pipe;

    localparam logic [31:0] NOP3 = 32'h0000_0013;
    localparam logic [7:0]  NOP5 = 8'hA5;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic [31:0] c3;
    logic        v3;
    logic [2:0]  st3, fl3;
    logic        acc3;
    logic [95:0] co3;
    logic [2:0]  vo3;
    logic [1:0]  in3;

    logic [7:0]  c5;
    logic        v5;
    logic [4:0]  st5, fl5;
    logic        acc5;
    logic [39:0] co5;
    logic [4:0]  vo5;
    logic [2:0]  in5;

    ctrl_pipe #(.STAGES(3), .CW(32), .NOP_CTRL(NOP3)) dut3 (
        .clk(clk), .reset(reset), .ctrl_i(c3), .valid_i(v3), .stall_i(st3),
        .flush_i(fl3), .accept_o(acc3), .ctrl_o(co3), .valid_o(vo3), .inflight_o(in3)
    );

    ctrl_pipe #(.STAGES(5), .CW(8), .NOP_CTRL(NOP5)) dut5 (
        .clk(clk), .reset(reset), .ctrl_i(c5), .valid_i(v5), .stall_i(st5),
        .flush_i(fl5), .accept_o(acc5), .ctrl_o(co5), .valid_o(vo5), .inflight_o(in5)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect3(input string tag, input logic [2:0] ev, input logic [31:0] e0,
                           input logic [31:0] e1, input logic [31:0] e2, input logic [1:0] en);
        $display("txn %s valid=%b s0=%0h s1=%0h s2=%0h inflight=%0d", tag, vo3,
                 co3[31:0], co3[63:32], co3[95:64], in3);
        chk({tag, "_valid"}, 64'(vo3), 64'(ev));
        chk({tag, "_s0"}, 64'(co3[31:0]), 64'(e0));
        chk({tag, "_s1"}, 64'(co3[63:32]), 64'(e1));
        chk({tag, "_s2"}, 64'(co3[95:64]), 64'(e2));
        chk({tag, "_inflight"}, 64'(in3), 64'(en));
    endtask

    // Loads C, B, A so stage 0..2 end up holding A, B, C.
    task automatic fill3(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
        st3 = '0; fl3 = '0; v3 = 1'b1;
        c3 = c; step();
        c3 = b; step();
        c3 = a; step();
        v3 = 1'b0;
        expect3("fill", 3'b111, a, b, c, 2'd3);
    endtask

    logic [31:0] sbq[$];

    task automatic sb_pop_s2();
        if (vo3[2]) begin
            if (sbq.size() == 0) begin
                chk("stream_sb_empty", 64'd1, 64'd0);
            end else begin
                logic [31:0] e;
                e = sbq.pop_front();
                $display("txn stream_out s2=%0h expect=%0h", co3[95:64], e);
                chk("stream_s2", 64'(co3[95:64]), 64'(e));
            end
        end
    endtask

    typedef struct {
        logic [39:0] c;
        logic [4:0]  v;
        logic [2:0]  n;
    } exp_t;
    exp_t exq[$];

    logic       mv [5];
    logic [7:0] mc [5];

    localparam logic [31:0] A = 32'hAAAA_0001;
    localparam logic [31:0] B = 32'hBBBB_0002;
    localparam logic [31:0] C = 32'hCCCC_0003;
    localparam logic [31:0] D = 32'hDDDD_0004;

    initial begin
        reset = 1'b1;
        c3 = '0; v3 = 1'b0; st3 = '0; fl3 = '0;
        c5 = '0; v5 = 1'b0; st5 = '0; fl5 = '0;

        // Reset then stream
        step();
        chk("reset_accept", 64'(acc3), 64'd0);
        step();
        expect3("reset", 3'b000, NOP3, NOP3, NOP3, 2'd0);
        reset = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            c3 = 32'(i); v3 = 1'b1;
            #1;
            chk("stream_accept", 64'(acc3), 64'd1);
            if (acc3) sbq.push_back(c3);
            step();
            sb_pop_s2();
            chk("stream_s0", 64'(co3[31:0]), 64'(i));
            chk("stream_inflight", 64'(in3), 64'((i < 3) ? i : 3));
        end
        v3 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            sb_pop_s2();
            chk("drain_inflight", 64'(in3), 64'(2 - i));
        end
        chk("stream_sb_left", 64'(sbq.size()), 64'd0);

        // Stall middle stage for two cycles
        fill3(A, B, C);
        st3 = 3'b010; v3 = 1'b1; c3 = D;
        #1;
        chk("stall_accept", 64'(acc3), 64'd0);
        step();
        expect3("stall1", 3'b011, A, B, NOP3, 2'd2);
        step();
        expect3("stall2", 3'b011, A, B, NOP3, 2'd2);
        st3 = '0; v3 = 1'b0;

        // Flush stage 1 and younger
        fill3(A, B, C);
        fl3 = 3'b010; v3 = 1'b1; c3 = D;
        #1;
        chk("flush_accept", 64'(acc3), 64'd0);
        step();
        expect3("flush", 3'b000, NOP3, NOP3, NOP3, 2'd0);
        fl3 = '0; v3 = 1'b0;

        // Flush beats stall
        fill3(A, B, C);
        st3 = 3'b100; fl3 = 3'b001; v3 = 1'b1; c3 = D;
        step();
        expect3("flush_vs_stall", 3'b110, NOP3, B, C, 2'd2);
        st3 = '0; fl3 = '0; v3 = 1'b0;

        // Reset during a stall with a full pipe
        fill3(A, B, C);
        st3 = 3'b010; v3 = 1'b1; c3 = D;
        step();
        expect3("pre_reset", 3'b011, A, B, NOP3, 2'd2);
        reset = 1'b1;
        #1;
        chk("midreset_accept", 64'(acc3), 64'd0);
        step();
        expect3("mid_reset", 3'b000, NOP3, NOP3, NOP3, 2'd0);
        reset = 1'b0; st3 = '0; v3 = 1'b0;

        // Randomized sweep on the 5-stage pipe
        for (int k = 0; k < 5; k++) begin mv[k] = 1'b0; mc[k] = NOP5; end
        for (int i = 0; i < 10000; i++) begin
            logic       r;
            logic [4:0] h, f;
            logic       ov [5];
            logic [7:0] oc [5];
            exp_t       e;
            int         cnt;

            r = (i == 0) || ($urandom_range(0, 199) == 0);
            for (int k = 0; k < 5; k++) begin
                st5[k] = ($urandom_range(0, 9) == 0);
                fl5[k] = ($urandom_range(0, 19) == 0);
            end
            v5 = ($urandom_range(0, 3) != 0);
            c5 = 8'($urandom);
            reset = r;

            h = '0; f = '0;
            for (int k = 4; k >= 0; k--) begin
                h[k] = st5[k] | ((k < 4) ? h[k+1] : 1'b0);
                f[k] = fl5[k] | ((k < 4) ? f[k+1] : 1'b0);
            end
            #1;
            chk("sw_accept", 64'(acc5), 64'(!h[0] && !f[0] && !r));

            if (!r && mv[4] && !f[4] && !h[4])
                $display("txn sweep_retire cycle=%0d ctrl=%0h", i, mc[4]);

            for (int k = 0; k < 5; k++) begin ov[k] = mv[k]; oc[k] = mc[k]; end
            for (int k = 0; k < 5; k++) begin
                if (r || f[k]) begin
                    mv[k] = 1'b0; mc[k] = NOP5;
                end else if (h[k]) begin
                    mv[k] = ov[k]; mc[k] = oc[k];
                end else if (k == 0) begin
                    mv[k] = v5; mc[k] = c5;
                end else if (f[k-1] || h[k-1]) begin
                    mv[k] = 1'b0; mc[k] = NOP5;
                end else begin
                    mv[k] = ov[k-1]; mc[k] = oc[k-1];
                end
            end
            cnt = 0;
            for (int k = 0; k < 5; k++) begin
                e.c[k*8 +: 8] = mc[k];
                e.v[k] = mv[k];
                cnt += int'(mv[k]);
            end
            e.n = 3'(cnt);
            exq.push_back(e);

            step();
            e = exq.pop_front();
            chk("sw_ctrl", 64'(co5), 64'(e.c));
            chk("sw_valid", 64'(vo5), 64'(e.v));
            chk("sw_inflight", 64'(in5), 64'(e.n));
        end
        reset = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
